// File: rtl/rec2pol_pkg.sv
// ============================================================================
// Module      : rec2pol_pkg
// Description : Shared types and constants for the rec2pol CORDIC arbiter.
//               Holds the arbiter FSM state type, default datapath width and
//               core latency, the Q16.16 fraction constant and a small
//               index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rec2pol_pkg;

    // Default operand/result width (Q16.16 signed)
    localparam int c_dw_default = 32;

    // Default CORDIC core latency from start to valid result
    localparam int c_latency_default = 32;

    // Q16.16 scaling factor, shared with the testbenches
    localparam real c_q16_frac = 65536.0;

    // Arbiter FSM states, binary encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width needed to hold an index in 0..n-1 (at least one bit)
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rec2pol_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational NREQ-wide request picker. Produces a one-hot
//               winner, its index and a valid flag. Round-robin search starts
//               at rr_ptr and wraps upward modulo NREQ.
//               Build option REC2POL_ARB_FIXED_PRIO_EN: fixed priority, lowest
//               index wins, and the rr_ptr port is removed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import rec2pol_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
)(
    input  logic [NREQ-1:0] req,
`ifndef REC2POL_ARB_FIXED_PRIO_EN
    input  logic [IW-1:0]   rr_ptr,
`endif
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx,
    output logic            win_valid
);

    int w_pos;

    // Scan requesters in priority order; the first active one wins
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        w_pos      = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef REC2POL_ARB_FIXED_PRIO_EN
            w_pos = k;
`else
            // rr_ptr is always kept below NREQ, so one subtraction wraps it
            w_pos = int'(rr_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
`endif
            if (!win_valid && req[w_pos]) begin
                win_valid         = 1'b1;
                win_onehot[w_pos] = 1'b1;
                win_idx           = IW'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rec2pol_arbiter.sv
// ============================================================================
// Module      : rec2pol_arbiter
// Description : Shares one rec2pol CORDIC core between NREQ requesters.
//               A req/gnt handshake captures the winner's operands, the core
//               is started and enabled for LATENCY cycles, then the modulus
//               and angle are latched and a one-cycle done strobe is returned
//               to the winner. One job per LATENCY+3 cycles.
//               Build option REC2POL_ARB_FIXED_PRIO_EN: fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rec2pol_arbiter
    import rec2pol_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = c_dw_default,
    parameter int LATENCY = c_latency_default
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   x_in,
    input  logic [NREQ*DW-1:0]   y_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        mod_out,
    output logic [DW-1:0]        angle_out,
    output logic                 cordic_start,
    output logic                 cordic_enable,
    output logic [DW-1:0]        cordic_x0,
    output logic [DW-1:0]        cordic_y0,
    input  logic [DW-1:0]        cordic_mod,
    input  logic [DW-1:0]        cordic_angle
);

    localparam int c_iw = idx_width(NREQ);
    localparam int c_cw = idx_width(LATENCY);

    // Counter load value: WAIT lasts LATENCY cycles after the ISSUE cycle
    localparam logic [c_cw-1:0] c_cnt_load = c_cw'(LATENCY - 1);

    arb_state_t        r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [NREQ-1:0]   r_win_onehot;

    logic [NREQ-1:0]   w_win_onehot;
    logic [c_iw-1:0]   w_win_idx;
    logic              w_win_valid;
    logic [DW-1:0]     w_x_sel;
    logic [DW-1:0]     w_y_sel;

`ifndef REC2POL_ARB_FIXED_PRIO_EN
    logic [c_iw-1:0]   r_rr_ptr;
    logic [c_iw-1:0]   r_win_idx;
`endif

    rr_pick #(
        .NREQ       (NREQ),
        .IW         (c_iw)
    ) u_rr_pick (
        .req        (req),
`ifndef REC2POL_ARB_FIXED_PRIO_EN
        .rr_ptr     (r_rr_ptr),
`endif
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .win_valid  (w_win_valid)
    );

    // Operand slice of the current winner
    assign w_x_sel = x_in[w_win_idx*DW +: DW];
    assign w_y_sel = y_in[w_win_idx*DW +: DW];

    // Arbiter FSM with registered grant, core control and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_win_onehot  <= '0;
            gnt           <= '0;
            done          <= '0;
            mod_out       <= '0;
            angle_out     <= '0;
            cordic_start  <= 1'b0;
            cordic_enable <= 1'b0;
            cordic_x0     <= '0;
            cordic_y0     <= '0;
`ifndef REC2POL_ARB_FIXED_PRIO_EN
            r_rr_ptr      <= '0;
            r_win_idx     <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below
            gnt          <= '0;
            done         <= '0;
            cordic_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state       <= ST_ISSUE;
                        gnt           <= w_win_onehot;
                        r_win_onehot  <= w_win_onehot;
                        cordic_start  <= 1'b1;
                        cordic_enable <= 1'b1;
                        cordic_x0     <= w_x_sel;
                        cordic_y0     <= w_y_sel;
                        r_cnt         <= c_cnt_load;
`ifndef REC2POL_ARB_FIXED_PRIO_EN
                        r_win_idx     <= w_win_idx;
`endif
                    end
                end

                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        // Core result is valid now; latch it and release core
                        r_state       <= ST_DONE;
                        done          <= r_win_onehot;
                        mod_out       <= cordic_mod;
                        angle_out     <= cordic_angle;
                        cordic_enable <= 1'b0;
`ifndef REC2POL_ARB_FIXED_PRIO_EN
                        r_rr_ptr      <= (r_win_idx == c_iw'(NREQ - 1)) ?
                                         '0 : r_win_idx + c_iw'(1);
`endif
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end

                ST_DONE: begin
                    // Mandatory IDLE cycle follows every job
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rec2pol_arbiter.sv
// ============================================================================
// Module      : tb_rec2pol_arbiter
// Description : Scoreboard bench for rec2pol_arbiter with a behavioural
//               fixed-latency CORDIC stand-in. Honours
//               REC2POL_ARB_FIXED_PRIO_EN for the contention order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rec2pol_arbiter;
    import rec2pol_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LAT  = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  x_in = '0;
    logic [NREQ*DW-1:0]  y_in = '0;
    logic [NREQ-1:0]     gnt, done;
    logic [DW-1:0]       mod_out, angle_out;
    logic                cordic_start, cordic_enable;
    logic [DW-1:0]       cordic_x0, cordic_y0;
    logic [DW-1:0]       cordic_mod, cordic_angle;

    rec2pol_arbiter #(.NREQ(NREQ), .DW(DW), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .x_in         (x_in),
        .y_in         (y_in),
        .gnt          (gnt),
        .done         (done),
        .mod_out      (mod_out),
        .angle_out    (angle_out),
        .cordic_start (cordic_start),
        .cordic_enable(cordic_enable),
        .cordic_x0    (cordic_x0),
        .cordic_y0    (cordic_y0),
        .cordic_mod   (cordic_mod),
        .cordic_angle (cordic_angle)
    );

    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] to_q(input real r);
        logic [DW-1:0] v;
        v = $rtoi(r * c_q16_frac);
        return v;
    endfunction

    function automatic real from_q(input logic [DW-1:0] v);
        return $itor($signed(v)) / c_q16_frac;
    endfunction

    function automatic logic [DW-1:0] ref_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        real rx, ry;
        rx = from_q(x);
        ry = from_q(y);
        return to_q($sqrt(rx * rx + ry * ry));
    endfunction

    function automatic logic [DW-1:0] ref_ang(input logic [DW-1:0] x, input logic [DW-1:0] y);
        real rx, ry;
        rx = from_q(x);
        ry = from_q(y);
        return to_q($atan2(ry, rx) * 180.0 / 3.14159265358979323846);
    endfunction

    // ---------------- CORDIC stand-in: result valid only LAT cycles after start ----------------
    int            core_cnt = 0;
    logic [DW-1:0] core_x = '0;
    logic [DW-1:0] core_y = '0;

    always @(posedge clk) begin
        if (cordic_start) begin
            core_cnt <= 1;
            core_x   <= cordic_x0;
            core_y   <= cordic_y0;
        end else if (!cordic_enable) begin
            core_cnt <= 0;
        end else if (core_cnt != 0 && core_cnt <= LAT) begin
            core_cnt <= core_cnt + 1;
        end
    end

    assign cordic_mod   = (core_cnt == LAT) ? ref_mod(core_x, core_y) : 32'hDEADBEEF;
    assign cordic_angle = (core_cnt == LAT) ? ref_ang(core_x, core_y) : 32'hBADC0FFE;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            idx;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        int            gap;
    } gnt_exp_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] m;
        logic [DW-1:0] a;
        real           hm;
        real           ha;
        bit            hand;
    } done_exp_t;

    gnt_exp_t  gq[$];
    done_exp_t dq[$];
    gnt_exp_t  ge;
    done_exp_t de;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_gnt_cyc  = -1000;
    int last_done_cyc = -1000;
    bit prev_gnt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_gnt(input int i, input int gap, input logic [DW-1:0] ex, input logic [DW-1:0] ey);
        gnt_exp_t g;
        g.idx = i; g.x = ex; g.y = ey; g.gap = gap;
        gq.push_back(g);
    endtask

    task automatic push_job(input int i, input int gap, input logic [DW-1:0] ex, input logic [DW-1:0] ey,
                            input bit hand, input real hm, input real ha);
        done_exp_t d;
        push_gnt(i, gap, ex, ey);
        d.idx = i; d.m = ref_mod(ex, ey); d.a = ref_ang(ex, ey);
        d.hm = hm; d.ha = ha; d.hand = hand;
        dq.push_back(d);
    endtask

    // Monitor: compares every grant and done against the queued expectations
    initial begin
        real diff;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_gnt = 1'b0;
            end else begin
                if (prev_gnt)
                    chk(gnt == '0 && !cordic_start, "gnt_start_one_cycle", {gnt, cordic_start}, 0);
                prev_gnt = (gnt != '0);
                if (gnt != '0) begin
                    if (gq.size() == 0) begin
                        chk(1'b0, "unexpected_gnt", gnt, 0);
                    end else begin
                        ge = gq.pop_front();
                        chk(gnt == (NREQ'(1) << ge.idx), "gnt_onehot", gnt, NREQ'(1) << ge.idx);
                        chk(cordic_start && cordic_enable, "start_enable_at_gnt", {cordic_start, cordic_enable}, 2'b11);
                        chk(cordic_x0 == ge.x, "cordic_x0", cordic_x0, ge.x);
                        chk(cordic_y0 == ge.y, "cordic_y0", cordic_y0, ge.y);
                        if (ge.gap >= 0)
                            chk(cyc - last_done_cyc == ge.gap, "done_to_gnt_gap", cyc - last_done_cyc, ge.gap);
                    end
                    last_gnt_cyc = cyc;
                end
                if (done != '0) begin
                    if (dq.size() == 0) begin
                        chk(1'b0, "unexpected_done", done, 0);
                    end else begin
                        de = dq.pop_front();
                        chk(done == (NREQ'(1) << de.idx), "done_onehot", done, NREQ'(1) << de.idx);
                        chk(cyc - last_gnt_cyc == LAT + 1, "gnt_to_done_latency", cyc - last_gnt_cyc, LAT + 1);
                        chk(mod_out == de.m, "mod_out", mod_out, de.m);
                        chk(angle_out == de.a, "angle_out", angle_out, de.a);
                        chk(!cordic_enable, "enable_low_in_done", cordic_enable, 0);
                        if (de.hand) begin
                            diff = from_q(mod_out) - de.hm;
                            if (diff < 0.0) diff = -diff;
                            chk(diff < 0.02, "mod_out_value", mod_out, to_q(de.hm));
                            diff = from_q(angle_out) - de.ha;
                            if (diff < 0.0) diff = -diff;
                            chk(diff < 0.02, "angle_out_value", angle_out, to_q(de.ha));
                        end
                    end
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ops(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
        x_in[i*DW +: DW] = x;
        y_in[i*DW +: DW] = y;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(output int w);
        w = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i]) w = i;
                break;
            end
        end
        if (w < 0) chk(1'b0, "gnt_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(1'b0, "done_timeout", 0, 1);
    endtask

    initial begin
        int w;
        int order[$];

        // Reset state
        rst_n = 1'b0;
        idle(3);
        chk(gnt == '0,          "rst_gnt",       gnt, 0);
        chk(done == '0,         "rst_done",      done, 0);
        chk(!cordic_start,      "rst_start",     cordic_start, 0);
        chk(!cordic_enable,     "rst_enable",    cordic_enable, 0);
        chk(cordic_x0 == '0,    "rst_x0",        cordic_x0, 0);
        chk(cordic_y0 == '0,    "rst_y0",        cordic_y0, 0);
        chk(mod_out == '0,      "rst_mod_out",   mod_out, 0);
        chk(angle_out == '0,    "rst_angle_out", angle_out, 0);
        rst_n = 1'b1;
        idle(2);

        // Contention: all four requesting in every IDLE
        for (int i = 0; i < NREQ; i++)
            set_ops(i, DW'((i + 1) << 16), DW'((2 * i + 1) << 16));
`ifdef REC2POL_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < order.size(); k++)
            push_job(order[k], (k == 0) ? -1 : 2, x_in[order[k]*DW +: DW], y_in[order[k]*DW +: DW], 1'b0, 0.0, 0.0);
        req = '1;
        for (int k = 0; k < order.size(); k++) begin
            wait_gnt(w);
            if (k == order.size() - 1) begin
                req = '0;
            end else begin
                if (w >= 0) req[w] = 1'b0;
                idle(3);
                if (w >= 0) req[w] = 1'b1;
            end
        end
        wait_done();
        idle(3);

        // Single job on requester 0
        set_ops(0, DW'(123 << 16), DW'(456 << 16));
        push_job(0, -1, 32'h007B0000, 32'h01C80000, 1'b1, 472.30, 74.91);
        req[0] = 1'b1;
        wait_gnt(w);
        req[0] = 1'b0;
        wait_done();
        idle(2);

        // Late request: req[2] raised during requester 1's WAIT
        set_ops(1, DW'(10 << 16), '0);
        set_ops(2, '0, DW'(7 << 16));
        push_job(1, -1, 32'h000A0000, 32'h00000000, 1'b1, 10.0, 0.0);
        push_job(2,  2, 32'h00000000, 32'h00070000, 1'b1, 7.0, 90.0);
        req[1] = 1'b1;
        wait_gnt(w);
        req[1] = 1'b0;
        idle(10);
        req[2] = 1'b1;
        wait_gnt(w);
        req[2] = 1'b0;
        wait_done();
        idle(2);

        // Withdrawn request: req[3] pulsed during requester 0's WAIT
        set_ops(0, DW'(3 << 16), DW'(4 << 16));
        set_ops(3, DW'(1 << 16), DW'(1 << 16));
        push_job(0, -1, 32'h00030000, 32'h00040000, 1'b1, 5.0, 53.13);
        req[0] = 1'b1;
        wait_gnt(w);
        req[0] = 1'b0;
        idle(5);
        req[3] = 1'b1;
        idle(1);
        req[3] = 1'b0;
        wait_done();
        idle(10);
        chk(gnt == '0, "withdrawn_no_gnt", gnt, 0);
        chk(!cordic_enable && !cordic_start, "idle_after_withdrawn", {cordic_enable, cordic_start}, 0);

        // Reset mid-job, then a normal job on requester 1
        set_ops(1, DW'(8 << 16), DW'(6 << 16));
        push_gnt(1, -1, 32'h00080000, 32'h00060000);
        req[1] = 1'b1;
        wait_gnt(w);
        req[1] = 1'b0;
        idle(22);
        rst_n = 1'b0;
        #1;
        chk(!cordic_enable,   "midrst_enable",    cordic_enable, 0);
        chk(gnt == '0,        "midrst_gnt",       gnt, 0);
        chk(done == '0,       "midrst_done",      done, 0);
        chk(!cordic_start,    "midrst_start",     cordic_start, 0);
        chk(mod_out == '0,    "midrst_mod_out",   mod_out, 0);
        chk(angle_out == '0,  "midrst_angle_out", angle_out, 0);
        chk(cordic_x0 == '0,  "midrst_x0",        cordic_x0, 0);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        chk(cordic_enable == 1'b0, "no_job_after_reset", cordic_enable, 0);
        push_job(1, -1, 32'h00080000, 32'h00060000, 1'b1, 10.0, 36.87);
        req[1] = 1'b1;
        wait_gnt(w);
        req[1] = 1'b0;
        wait_done();
        idle(2);

        // Held result: (3,4) on requester 2, then (-5,0) on requester 3
        set_ops(2, DW'(3 << 16), DW'(4 << 16));
        set_ops(3, 32'hFFFB0000, '0);
        push_job(2, -1, 32'h00030000, 32'h00040000, 1'b1, 5.0, 53.13);
        push_job(3,  2, 32'hFFFB0000, 32'h00000000, 1'b1, 5.0, 180.0);
        req[2] = 1'b1;
        req[3] = 1'b1;
        wait_gnt(w);
        req[2] = 1'b0;
        wait_done();
        wait_gnt(w);
        req[3] = 1'b0;
        idle(10);
        chk(mod_out == ref_mod(32'h00030000, 32'h00040000), "held_mod_out", mod_out,
            ref_mod(32'h00030000, 32'h00040000));
        chk(angle_out == ref_ang(32'h00030000, 32'h00040000), "held_angle_out", angle_out,
            ref_ang(32'h00030000, 32'h00040000));
        wait_done();
        idle(3);

        chk(gq.size() == 0, "gnt_queue_drained", gq.size(), 0);
        chk(dq.size() == 0, "done_queue_drained", dq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rec2pol_arbiter.md
# rec2pol_arbiter

Shares one rec2pol CORDIC core (rectangular-to-polar, fixed 32-cycle latency, start/enable handshake) between NREQ requesters, such as the txtrigger controller and the pulse-shaping front end. Accepts operand pairs on a req/gnt handshake and picks a requester round-robin. Sequences the core's start and enable pins, waits the core latency, then returns the modulus and angle to the winner with a one-cycle done strobe. Sits between the requesters and the single CORDIC instance.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 32: operand/result width, Q16.16 signed
- LATENCY, 32: CORDIC cycles from start to valid result, ≥2
- clock  in  1  master clock, 100 MHz, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req  in  NREQ  request per requester; level, held until gnt
- x_in  in  NREQ*DW  x operand per requester, slice i = bits [i*DW +: DW]
- y_in  in  NREQ*DW  y operand per requester, same packing
- gnt  out  NREQ  one-hot, one-cycle grant; operands sampled this cycle
- done  out  NREQ  one-hot, one-cycle result-valid strobe
- mod_out  out  DW  latched modulus of the last completed job
- angle_out  out  DW  latched angle of the last completed job
- cordic_start  out  1  one-cycle start pulse to the core
- cordic_enable  out  1  core enable, high while the job is in flight
- cordic_x0, cordic_y0  out  DW  registered operands to the core
- cordic_mod, cordic_angle  in  DW  core results

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Encoding is binary.
- IDLE: if any req bit is 1, the arbiter picks the winner w and goes to ISSUE. Otherwise it stays in IDLE.
- Winner selection: round-robin. The search starts at rr_ptr and wraps modulo NREQ.
- ISSUE (one cycle):
  - gnt[w]=1, cordic_start=1, cordic_enable=1.
  - cordic_x0/y0 take slice w of x_in/y_in.
  - The counter loads LATENCY-1.
- WAIT:
  - cordic_enable=1 and the counter decrements.
  - When the counter is 0, the FSM goes to DONE.
- DONE (one cycle):
  - mod_out/angle_out latch cordic_mod/cordic_angle.
  - done[w]=1.
  - cordic_enable=0.
  - rr_ptr = (w+1) mod NREQ.
  - The FSM goes to IDLE.
- Requests that arrive during ISSUE/WAIT/DONE stay pending and are arbitrated in the next IDLE.
- req[w] is ignored after gnt[w]. The requester must drop it the cycle after gnt; if it is still high in IDLE, the arbiter treats it as a new job.
- A req that drops before it is granted is simply not served.
- No arithmetic is done on the data; operands and results pass through unchanged.

## Timing
- Reset values: gnt=0, done=0, cordic_start=0, cordic_enable=0, cordic_x0/y0=0, mod_out/angle_out=0, rr_ptr=0, state=IDLE.
- Request to grant: req sampled high at edge k gives gnt and cordic_start high in cycle k..k+1.
- Grant to done: done[w] is high exactly LATENCY+1 cycles after gnt[w].
- Result timing: mod_out/angle_out are valid from the done edge and hold until the next DONE.
- Throughput: one job per LATENCY+3 cycles, including the mandatory IDLE cycle between jobs.
- Simultaneous requests: the requester nearest rr_ptr, wrapping upward, wins.
- Reset asserted mid-job: outputs return to reset values immediately. No done is issued, and the in-flight job is lost.
- Reset release: the FSM is in IDLE and arbitration may start on the first rising edge after deassertion.

## Configuration
- REC2POL_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. rr_ptr is not implemented.
  - Undefined (default): round-robin as described above.

## Structure
- Package rec2pol_pkg holds:
  - the FSM state typedef
  - the default DW and LATENCY constants
  - the Q16.16 fraction constant (65536.0) shared with the testbenches
- One sub-module, rr_pick: combinational NREQ-wide round-robin/priority picker. Inputs are req and rr_ptr; outputs are a one-hot winner and its index. It honours REC2POL_ARB_FIXED_PRIO_EN.

## Test plan
- Single job: req[0] with x=123<<16, y=456<<16.
  - Expect gnt[0] and cordic_start for 1 cycle, cordic_x0=0x007B0000, cordic_y0=0x01C80000.
  - Expect done[0] 33 cycles later, mod_out≈472.30, angle_out≈74.91°.
- Contention: req=4'b1111 held in every IDLE.
  - Expect grant order 0,1,2,3,0.
  - With REC2POL_ARB_FIXED_PRIO_EN, expect 0,0,0.
- Late request: req[2] raised during requester 1's WAIT.
  - Expect gnt[2] exactly 2 cycles after done[1].
- Withdrawn request: req[3] pulsed 1 cycle while the FSM is in WAIT, then dropped.
  - Expect no gnt[3] and the FSM to stay in IDLE afterwards.
- Reset mid-job: reset=0 at WAIT count 10.
  - Expect cordic_enable=0 and gnt/done=0 immediately, no done strobe.
  - After release, req[1] is served normally with latency 33.
- Held result: two back-to-back jobs (3,4) then (-5,0).
  - Expect mod_out=5.0 after each job.
  - Expect angle_out 53.13° after the first, then 180.0° after the second.
